// File: rtl/fetch_pkg.sv
// Shared widths, defaults and the prefetch entry type for the instruction-fetch front end.
package fetch_pkg;

  localparam int ADDR_W = 16;
  localparam int INSTR_W = 16;
  localparam int FETCH_FIFO_DEPTH = 4;
  localparam logic [ADDR_W-1:0] FETCH_RESET_PC = 16'h0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Sequential PC successor; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t with wrap-around pointers, a synchronous clear
// and a registered head. DEPTH must be a power of two, at least 2.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_FIFO_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  fetch_entry_t       wr_data,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count == FULL_CNT);
    empty   = (count == '0);
    do_pop  = pop && !empty;
    // A push at full is only legal when the head leaves in the same edge.
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives the 1-cycle ROM and feeds decode
// from a prefetch FIFO. Define FETCH_PERF_EN to add stall/flush counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                FIFO_DEPTH = FETCH_FIFO_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC   = FETCH_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_q,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               decode_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [ADDR_W-1:0]  pc_out
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        stall_cycles,
  output logic [15:0]        flush_count
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  occupancy;
  logic              issue;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  // Handshake: an instruction transfers to decode on a clock edge where instr_valid
  // and decode_ready are both high and redirect is low; otherwise the head holds.
  always_comb begin
    occupancy   = count + CNT_W'(inflight);
    issue       = redirect || (occupancy < DEPTH_CNT);
    rom_address = redirect ? redirect_pc : fetch_pc;
    instr_valid = (count != '0);
    push        = inflight && !redirect;
    pop         = instr_valid && decode_ready && !redirect;
    push_entry  = '{instr: rom_q, pc: inflight_pc};
    instruction_out = head.instr;
    pc_out          = head.pc;
  end

  // rom_address already reflects redirect priority, so one path serves both issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (issue) begin
      fetch_pc    <= pc_next(rom_address);
      inflight    <= 1'b1;
      inflight_pc <= rom_address;
    end else begin
      inflight    <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .clear   (redirect),
    .wr_data (push_entry),
    .head    (head),
    .count   (count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (instr_valid && !decode_ready && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (redirect && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a scoreboard queue of expected {instr, pc} transfers,
// a negedge monitor, and direct checks for latency, stall, redirect and reset behaviour.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic               clk;
  logic               reset;
  logic [ADDR_W-1:0]  rom_address;
  logic [INSTR_W-1:0] rom_q;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               decode_ready;
  logic               instr_valid;
  logic [INSTR_W-1:0] instruction_out;
  logic [ADDR_W-1:0]  pc_out;

  logic [ADDR_W-1:0]  rom_address_w;
  logic [INSTR_W-1:0] rom_q_w;
  logic               redirect_w;
  logic [ADDR_W-1:0]  redirect_pc_w;
  logic               decode_ready_w;
  logic               instr_valid_w;
  logic [INSTR_W-1:0] instruction_out_w;
  logic [ADDR_W-1:0]  pc_out_w;

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;
  logic [15:0] stall_cycles_w;
  logic [15:0] flush_count_w;
`endif

  int          checks;
  int          failures;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w_q[$];

  fetch_stage #(.FIFO_DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .rom_address     (rom_address),
    .rom_q           (rom_q),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .decode_ready    (decode_ready),
    .instr_valid     (instr_valid),
    .instruction_out (instruction_out),
    .pc_out          (pc_out)
`ifdef FETCH_PERF_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
`endif
  );

  fetch_stage #(.FIFO_DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut_w (
    .clk             (clk),
    .reset           (reset),
    .rom_address     (rom_address_w),
    .rom_q           (rom_q_w),
    .redirect        (redirect_w),
    .redirect_pc     (redirect_pc_w),
    .decode_ready    (decode_ready_w),
    .instr_valid     (instr_valid_w),
    .instruction_out (instruction_out_w),
    .pc_out          (pc_out_w)
`ifdef FETCH_PERF_EN
    ,
    .stall_cycles    (stall_cycles_w),
    .flush_count     (flush_count_w)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return 16'hA000 + a;
  endfunction

  // Synchronous ROM model, one cycle of read latency.
  always @(posedge clk) begin
    rom_q   <= rom_word(rom_address);
    rom_q_w <= rom_word(rom_address_w);
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] pc);
    exp_q.push_back({rom_word(pc), pc});
  endtask

  task automatic push_exp_w(input logic [ADDR_W-1:0] pc);
    exp_w_q.push_back({rom_word(pc), pc});
  endtask

  task automatic assert_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instruction_out), 32'd0);
    check("rst_pc_out", 32'(pc_out), 32'd0);
    check("rst_rom_addr", 32'(rom_address), 32'h0000);
    check("rst_rom_addr_w", 32'(rom_address_w), 32'hFFFE);
`ifdef FETCH_PERF_EN
    check("rst_stall_cycles", 32'(stall_cycles), 32'd0);
    check("rst_flush_count", 32'(flush_count), 32'd0);
`endif
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait for the selected scoreboard to empty, then stall that consumer.
  task automatic drain(input bit wrap_sel, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(posedge clk);
      #1;
      if ((wrap_sel ? exp_w_q.size() : exp_q.size()) == 0) done = 1'b1;
    end
    if (wrap_sel) decode_ready_w = 1'b0;
    else          decode_ready   = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout left=%0d required=0",
               wrap_sel ? exp_w_q.size() : exp_q.size());
      if (wrap_sel) exp_w_q.delete();
      else          exp_q.delete();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (int'(dut.u_fifo.count) > DEPTH) begin
        failures++;
        $display("FAIL fifo_count_bound actual=%0d limit=%0d", dut.u_fifo.count, DEPTH);
      end
      checks++;
      if (dut.push && (int'(dut.u_fifo.count) == DEPTH) && !dut.pop) begin
        failures++;
        $display("FAIL push_at_full actual=push required=no_push");
      end
      if (instr_valid && decode_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_xfer actual=%h required=none", {instruction_out, pc_out});
        end else begin
          check("xfer", {instruction_out, pc_out}, exp_q.pop_front());
        end
      end
      if (instr_valid_w && decode_ready_w && !redirect_w) begin
        if (exp_w_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_xfer_w actual=%h required=none", {instruction_out_w, pc_out_w});
        end else begin
          check("xfer_w", {instruction_out_w, pc_out_w}, exp_w_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = '0;
    decode_ready   = 1'b0;
    redirect_w     = 1'b0;
    redirect_pc_w  = '0;
    decode_ready_w = 1'b0;
    assert_reset();

    // Streaming from reset with decode always ready.
    for (int k = 0; k < 8; k++) push_exp(16'(k));
    decode_ready = 1'b1;
    release_reset();
    @(negedge clk);
    check("c0_valid", 32'(instr_valid), 32'd0);
    check("c0_rom_addr", 32'(rom_address), 32'h0001);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("stream_no_bubble", 32'(instr_valid), 32'd1);
    end
    drain(1'b0, 20);
    assert_reset();

    // Stall after two transfers: head frozen, FIFO fills, issue stops.
    push_exp(16'h0000);
    push_exp(16'h0001);
    decode_ready = 1'b1;
    release_reset();
    drain(1'b0, 20);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("stall_head_pc", 32'(pc_out), 32'h0002);
      check("stall_valid", 32'(instr_valid), 32'd1);
    end
    check("stall_count_full", 32'(dut.u_fifo.count), 32'd4);
    check("stall_rom_addr", 32'(rom_address), 32'h0006);
    for (int k = 2; k < 10; k++) push_exp(16'(k));
    @(posedge clk);
    #1;
    decode_ready = 1'b1;
    drain(1'b0, 30);
    assert_reset();

    // Redirect to 0x0040 with three entries buffered.
    release_reset();
    repeat (4) @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge clk);
    check("redir_rom_addr", 32'(rom_address), 32'h0040);
    check("redir_count_before", 32'(dut.u_fifo.count), 32'd3);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    check("redir_valid_next", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("redir_valid_2", 32'(instr_valid), 32'd1);
    check("redir_pc_2", 32'(pc_out), 32'h0040);
    for (int k = 'h40; k < 'h45; k++) push_exp(16'(k));
    @(posedge clk);
    #1;
    decode_ready = 1'b1;
    drain(1'b0, 20);

    // Back-to-back redirects while stalled; the first target must never appear.
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    @(posedge clk);
    #1;
    redirect_pc = 16'h0080;
    @(negedge clk);
    check("bb_valid_1", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    for (int k = 'h80; k < 'h84; k++) push_exp(16'(k));
    decode_ready = 1'b1;
    @(negedge clk);
    check("bb_valid_2", 32'(instr_valid), 32'd0);
    drain(1'b0, 20);
    assert_reset();

    // PC wrap on the instance reset to 0xFFFE.
    push_exp_w(16'hFFFE);
    push_exp_w(16'hFFFF);
    push_exp_w(16'h0000);
    push_exp_w(16'h0001);
    decode_ready_w = 1'b1;
    release_reset();
    drain(1'b1, 20);
    assert_reset();

    // Five stall edges then two redirects, followed by a reset mid-run.
    for (int k = 0; k < 4; k++) push_exp(16'(k));
    decode_ready = 1'b1;
    release_reset();
    drain(1'b0, 20);
    repeat (5) @(posedge clk);
    #1;
    decode_ready = 1'b1;
    redirect     = 1'b1;
    redirect_pc  = 16'h0100;
    @(posedge clk);
    #1;
    redirect_pc = 16'h0200;
    @(posedge clk);
    #1;
    redirect     = 1'b0;
    decode_ready = 1'b0;
    @(negedge clk);
    check("perf_valid_after_redir", 32'(instr_valid), 32'd0);
`ifdef FETCH_PERF_EN
    check("perf_stall_cycles", 32'(stall_cycles), 32'd5);
    check("perf_flush_count", 32'(flush_count), 32'd2);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrun_valid_before", 32'(instr_valid), 32'd1);
    check("midrun_pc_before", 32'(pc_out), 32'h0200);
    assert_reset();
    release_reset();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
